// File: rtl/i3c_bus_arbiter.sv
// I3C bus mastership arbiter: fixed-priority primary, round-robin secondaries; grant one edge after request.
// No backpressure: owners hold req and release with done; the hold timeout revokes; a gap follows every release.
module i3c_bus_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BUS_FREE_CYCLES = 4,
  parameter int HOLD_TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       bus_busy,
  output logic                       timeout_flag
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int HC_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int FC_W = (BUS_FREE_CYCLES > 1) ? $clog2(BUS_FREE_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TIMEOUT - 1);
  localparam logic [FC_W-1:0] FREE_LOAD = FC_W'(BUS_FREE_CYCLES - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0] FIRST_SEC = ID_W'(1);

  typedef enum logic [1:0] {IDLE, OWNED, BUS_FREE} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_nxt;
  logic [HC_W-1:0]     hold_cnt, hold_nxt;
  logic [FC_W-1:0]     free_cnt, free_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [ID_W-1:0]     owner_nxt;
  logic                busy_nxt;
  logic                tflag_nxt;

  logic                sec_found;
  logic [ID_W-1:0]     sec_id;
  logic [ID_W-1:0]     win_id;
  logic                owner_rel;
  logic                hold_hit;

  // Secondary search starts at rr_ptr and wraps from the last index back to 1, skipping the primary.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_t;
    sec_found = 1'b0;
    sec_id    = '0;
    idx       = 0;
    idx_t     = '0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
      idx_t = ID_W'(idx);
      if (!sec_found && req[idx_t]) begin
        sec_found = 1'b1;
        sec_id    = idx_t;
      end
    end
  end

  assign win_id    = req[0] ? '0 : sec_id;
  assign owner_rel = done[owner_id] | ~req[owner_id];
  assign hold_hit  = (HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|req) state_nxt = OWNED;
      OWNED:    if (owner_rel || hold_hit) state_nxt = BUS_FREE;
      BUS_FREE: if (free_cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    grant_nxt = grant;
    owner_nxt = owner_id;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    free_nxt  = free_cnt;
    tflag_nxt = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (state_nxt == OWNED) begin
          grant_nxt         = '0;
          grant_nxt[win_id] = 1'b1;
          owner_nxt         = win_id;
          hold_nxt          = '0;
          if (!req[0]) rr_nxt = (win_id == LAST_ID) ? FIRST_SEC : win_id + 1'b1;
        end
      end
      OWNED: begin
        hold_nxt = hold_cnt + 1'b1;
        if (state_nxt == BUS_FREE) begin
          grant_nxt = '0;
          free_nxt  = FREE_LOAD;
          tflag_nxt = ~owner_rel;  // a coincident release wins over the timeout
        end
      end
      BUS_FREE: begin
        if (free_cnt != '0) free_nxt = free_cnt - 1'b1;
      end
      default: grant_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant        <= '0;
      owner_id     <= '0;
      bus_busy     <= 1'b0;
      timeout_flag <= 1'b0;
      rr_ptr       <= FIRST_SEC;
      hold_cnt     <= '0;
      free_cnt     <= '0;
    end else begin
      grant        <= grant_nxt;
      owner_id     <= owner_nxt;
      bus_busy     <= busy_nxt;
      timeout_flag <= tflag_nxt;
      rr_ptr       <= rr_nxt;
      hold_cnt     <= hold_nxt;
      free_cnt     <= free_nxt;
    end
  end

endmodule

// File: tb/tb_i3c_bus_arbiter.sv
// Directed bench for i3c_bus_arbiter with a grant scoreboard (owner, hold length, gap).
module tb_i3c_bus_arbiter;

  localparam int N = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] done  = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner_id;
  logic         bus_busy;
  logic         timeout_flag;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int id;
    int len;
    int gap;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  bit           cur_valid = 1'b0;
  logic [N-1:0] prev_g    = '0;
  int           gap_cnt   = 0;
  int           own_len   = 0;

  always #5 clk = ~clk;

  i3c_bus_arbiter #(
    .NUM_REQ(N),
    .BUS_FREE_CYCLES(4),
    .HOLD_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .grant(grant),
    .owner_id(owner_id),
    .bus_busy(bus_busy),
    .timeout_flag(timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic void expect_grant(input int id, input int len, input int gap);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.gap = gap;
    sb.push_back(e);
  endfunction

  // Scoreboard: every new grant pops one expectation; len/gap of 0 means unchecked.
  always @(negedge clk) begin
    if (reset) begin
      prev_g    = '0;
      gap_cnt   = 0;
      own_len   = 0;
      cur_valid = 1'b0;
    end else begin
      if (grant != '0 && prev_g == '0) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur       = sb.pop_front();
          cur_valid = 1'b1;
          chk("sb_owner", onehot_idx(grant), cur.id);
          if (cur.gap != 0) chk("sb_gap", gap_cnt, cur.gap);
        end
        chk("sb_onehot", $onehot(grant), 1);
        own_len = 0;
      end
      if (grant == '0 && prev_g != '0) begin
        if (cur_valid && cur.len != 0) chk("sb_len", own_len, cur.len);
        cur_valid = 1'b0;
        gap_cnt   = 0;
      end
      if (grant != '0) begin
        own_len++;
        chk("busy_while_grant", bus_busy, 1);
      end else begin
        gap_cnt++;
      end
      prev_g = grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    done  = '0;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_tflag", timeout_flag, 0);
    reset = 1'b0;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_busy", bus_busy, 0);
  endtask

  task automatic wait_grant(input int id, output int lat);
    lat = 0;
    while (grant == '0 && lat < 30) begin
      tick();
      lat++;
    end
    chk("grant_seen", grant != '0, 1);
    chk("owner_id", owner_id, id);
    chk("grant_vec", grant, 1 << id);
    chk("grant_busy", bus_busy, 1);
  endtask

  // Wait for the grant to id, hold it for 'hold' cycles, then pulse done (optionally dropping req).
  task automatic serve(input int id, input int hold, input bit drop);
    int lat;
    wait_grant(id, lat);
    repeat (hold - 1) tick();
    done[id] = 1'b1;
    if (drop) req[id] = 1'b0;
    tick();
    done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;

    // Single secondary request, release, then the bus-free gap.
    do_reset();
    expect_grant(1, 1, 0);
    req = 4'b0010;
    wait_grant(1, lat);
    chk("req_latency", lat, 1);
    done = 4'b0010;
    req  = 4'b0000;
    tick();
    done = '0;
    chk("rel_grant", grant, 0);
    chk("rel_busy", bus_busy, 1);
    repeat (3) tick();
    chk("free_busy", bus_busy, 1);
    tick();
    chk("free_end_busy", bus_busy, 0);
    tick();
    chk("idle_stay_grant", grant, 0);

    // Round robin among continuously requesting secondaries.
    do_reset();
    expect_grant(1, 3, 0);
    expect_grant(2, 3, 5);
    expect_grant(3, 3, 5);
    expect_grant(1, 3, 5);
    req = 4'b1110;
    serve(1, 3, 1'b0);
    serve(2, 3, 1'b0);
    serve(3, 3, 1'b0);
    serve(1, 3, 1'b0);
    req = '0;
    repeat (6) tick();

    // Primary priority; primary grant does not move the round-robin pointer.
    do_reset();
    expect_grant(0, 2, 0);
    expect_grant(1, 2, 5);
    expect_grant(3, 2, 5);
    req = 4'b1011;
    serve(0, 2, 1'b1);
    serve(1, 2, 1'b1);
    serve(3, 2, 1'b1);
    repeat (6) tick();

    // Hold timeout revokes after exactly 16 cycles.
    do_reset();
    expect_grant(2, 16, 0);
    req = 4'b0100;
    wait_grant(2, lat);
    repeat (15) tick();
    chk("to_grant_held", grant, 4'b0100);
    chk("to_flag_early", timeout_flag, 0);
    tick();
    chk("to_grant_clr", grant, 0);
    chk("to_flag", timeout_flag, 1);
    chk("to_busy", bus_busy, 1);
    tick();
    chk("to_flag_pulse", timeout_flag, 0);
    chk("to_free_busy", bus_busy, 1);
    repeat (2) tick();
    chk("to_free_busy2", bus_busy, 1);
    tick();
    chk("to_idle_busy", bus_busy, 0);
    req = '0;
    repeat (3) tick();

    // Asynchronous reset in the middle of an ownership.
    do_reset();
    expect_grant(3, 0, 0);
    req = 4'b1000;
    wait_grant(3, lat);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_owner", owner_id, 0);
    chk("arst_busy", bus_busy, 0);
    chk("arst_tflag", timeout_flag, 0);
    req = 4'b1010;
    tick();
    reset = 1'b0;
    expect_grant(1, 1, 0);
    serve(1, 1, 1'b1);
    req = '0;
    repeat (6) tick();

    // Non-owner done ignored; owner done coincident with timeout is a release.
    do_reset();
    expect_grant(1, 16, 0);
    req = 4'b0010;
    wait_grant(1, lat);
    repeat (4) tick();
    done = 4'b0100;
    tick();
    done = '0;
    chk("foreign_done_grant", grant, 4'b0010);
    repeat (10) tick();
    done = 4'b0010;
    tick();
    done = '0;
    req  = '0;
    chk("coinc_grant", grant, 0);
    chk("coinc_tflag", timeout_flag, 0);
    tick();
    chk("coinc_tflag_after", timeout_flag, 0);
    repeat (8) tick();

    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
